// File: rtl/note_stepper.sv
// Note-period stepper: divides the clock to a 1 ms base and pulses o_step once per
// latched timeunit, tracking song position. Define NOTE_STEPPER_FASTSIM_EN to drop the prescaler (1 cycle = 1 ms).
module note_stepper #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned STEP_W      = 8,
  parameter int unsigned SONG_LEN    = 200
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic [9:0]        i_timeunit,
  output logic              o_step,
  output logic [STEP_W-1:0] o_step_idx,
  output logic              o_running,
  output logic              o_paused,
  output logic              o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [9:0]        r_ms_cnt, w_ms_nxt;
  logic [9:0]        r_tu_lat, w_tu_nxt, w_tu_load;
  logic [STEP_W-1:0] r_step_idx, w_idx_nxt, w_idx_inc;
  logic              r_step, w_step_nxt;
  logic              w_tick;
  logic              w_advance;
  logic              w_hit;

  // Resuming from PAUSE counts on the same edge, so pause costs exactly its own cycles.
  assign w_advance = !i_start && !i_pause && (r_state == S_RUN || r_state == S_PAUSE);
  assign w_tu_load = (i_timeunit == 10'd0) ? 10'd1 : i_timeunit;
  assign w_hit     = w_advance && w_tick && (r_ms_cnt == r_tu_lat - 10'd1);
  assign w_idx_inc = r_step_idx + 1'b1;

`ifdef NOTE_STEPPER_FASTSIM_EN
  assign w_tick = 1'b1;
`else
  localparam int unsigned DIV   = CLK_FREQ_HZ / 1000;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0] r_pre;

  assign w_tick = (r_pre == PRE_W'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
    end else if (i_start) begin
      r_pre <= '0;
    end else if (w_advance) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ms_nxt    = r_ms_cnt;
    w_tu_nxt    = r_tu_lat;
    w_idx_nxt   = r_step_idx;
    w_step_nxt  = 1'b0;
    if (i_start) begin
      w_state_nxt = S_RUN;
      w_ms_nxt    = '0;
      w_idx_nxt   = '0;
      w_tu_nxt    = w_tu_load;
    end else begin
      if (r_state == S_RUN && i_pause)
        w_state_nxt = S_PAUSE;
      if (r_state == S_PAUSE && !i_pause)
        w_state_nxt = S_RUN;
      if (w_hit) begin
        w_ms_nxt   = '0;
        w_step_nxt = 1'b1;
        w_idx_nxt  = w_idx_inc;
        w_tu_nxt   = w_tu_load;
        if (w_idx_inc == STEP_W'(SONG_LEN))
          w_state_nxt = S_DONE;
      end else if (w_advance && w_tick) begin
        w_ms_nxt = r_ms_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ms_cnt   <= '0;
      r_tu_lat   <= 10'd1;
      r_step_idx <= '0;
      r_step     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ms_cnt   <= w_ms_nxt;
      r_tu_lat   <= w_tu_nxt;
      r_step_idx <= w_idx_nxt;
      r_step     <= w_step_nxt;
    end
  end

  assign o_step     = r_step;
  assign o_step_idx = r_step_idx;
  assign o_running  = (r_state == S_RUN);
  assign o_paused   = (r_state == S_PAUSE);
  assign o_done     = (r_state == S_DONE);

endmodule

// File: doc/note_stepper.md
# note_stepper

Downstream consumer of the difficulty stage's `timeunit` value (note period in milliseconds). It converts the system clock into a millisecond base, then emits one single-cycle `step` pulse every `timeunit` ms. The note-scroll and judgement logic use `step` to advance the chart by one position. The block tracks the song position, supports pause and resume, and flags the end of the song.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency. Millisecond divider `DIV = CLK_FREQ_HZ/1000`.
- `STEP_W`, default 8: width of the step index.
- `SONG_LEN`, default 200: number of steps in a song. Must be in 1..2^STEP_W-1.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level sampled each cycle. High starts the song, or restarts it from any state.
- `pause` input 1: level. High freezes timing while running.
- `timeunit` input 10: note period in ms, from the difficulty stage.
- `step` output 1: registered one-cycle pulse per elapsed note period.
- `step_idx` output STEP_W: count of steps issued since the last start.
- `running` output 1: high in RUN.
- `paused` output 1: high in PAUSE.
- `done` output 1: high in DONE, held until the next start.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- Internal registers:
  - `pre` prescaler, width `$clog2(DIV)`.
  - `ms_cnt`, 10 bits.
  - `tu_lat`, 10 bits: latched period.
- Timeunit latch: `tu_lat` is loaded from `timeunit` on the start edge and on every step edge. A `timeunit` of 0 is latched as 1. Changes to `timeunit` in mid-period take effect at the next period.
- Transitions on each edge, first matching rule wins:
  - `start`=1, any state → RUN. Clear `pre`, `ms_cnt`, `step_idx`; latch `tu_lat`; `step`=0.
  - RUN and `pause`=1 → PAUSE. Counters hold.
  - PAUSE and `pause`=0 → RUN. Counting resumes from the held values.
  - RUN, otherwise: advance the counters.
    - `pre` increments and wraps at DIV-1.
    - On the wrap edge, `ms_cnt` increments.
    - If `ms_cnt==tu_lat-1` at that edge:
      - `ms_cnt`←0, `step`←1, `step_idx`←`step_idx`+1, relatch `tu_lat`.
      - If the new `step_idx` equals SONG_LEN, the state becomes DONE.
  - IDLE and DONE hold all counters.
- `step` is high for exactly one cycle per period. It is never asserted outside RUN-driven edges.
- The final step is still pulsed, on the same edge DONE is entered.
- `step_idx` never exceeds SONG_LEN and does not wrap.

## Timing
- Reset values: `step`=0, `step_idx`=0, `running`=0, `paused`=0, `done`=0. `tu_lat`=1, `pre`=0, `ms_cnt`=0.
- With `start` sampled at edge E0, the k-th `step` is high after edge E0 + k·`tu_lat`·DIV. This assumes a constant `timeunit` and no pause.
- Pause adds exactly one cycle of delay per cycle spent in PAUSE, plus zero cycles of entry/exit overhead. `pre` does not advance on the edge that enters PAUSE.
- `running`, `paused` and `done` are registered and decoded from the state, so they change on the same edge as the state.
- Asserting `rst_n` low mid-song returns all outputs to reset values immediately, without waiting for a clock edge.
- `start` held high for several cycles keeps restarting the song. No step is issued until `start` falls.
- `start` and `pause` high together: start wins, and the next state is RUN. If `pause` is still high on the following edge, the block then enters PAUSE.

## Configuration
- `NOTE_STEPPER_FASTSIM_EN`
  - Defined: the prescaler is removed and every clock cycle counts as one ms tick (DIV=1), so simulations run in `timeunit` cycles per step.
  - Undefined: DIV = `CLK_FREQ_HZ/1000` as specified above.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `NOTE_STEPPER_FASTSIM_EN` defined and `SONG_LEN`=4.
- Reset, then `start`=1 for one cycle at E0 with `timeunit`=3 → `step` high after E3, E6, E9 and E12, with `step_idx`=1..4.
  - `done`=1 and `running`=0 from E12.
  - No `step` at E15.
- `timeunit`=0, start → `step` is high every cycle, after E1, E2, E3 and E4.
- `timeunit`=5, start at E0; drive `pause`=1 during E2..E4 (three edges) → `paused`=1 after E2, and the first `step` moves from E5 to after E8.
- `timeunit`=4, start at E0; change `timeunit` to 2 after E1 → steps after E4, E6 and E8, showing the new value applied from the second period.
- Pull `rst_n` low mid-song, with `step_idx`=2 → all outputs go to 0 asynchronously. After release, a `start` restarts from `step_idx`=0.
- In DONE, assert `start` and `pause` together for one edge → the block enters RUN with counters cleared, then moves to PAUSE on the next edge, with `done`=0.
